comparador_serial: RTL and testbench

- Parametrised, multi-cycle magnitude comparator for two WIDTH-bit operands.
- Compares one DIGIT-bit slice per clock, MSB-first, and stops early at the first differing slice.
- Supports unsigned and two's-complement signed modes, selected per operation.
- Start/busy/done handshake; sits beside the datapath where area matters more than single-cycle latency.

---
 rtl/comparador_pkg.sv | 13 +
 rtl/comparador_digito.sv | 28 ++
 rtl/comparador_serial.sv | 105 ++++++++++
 tb/tb_comparador_serial.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/comparador_pkg.sv
// Shared encodings for the serial magnitude comparator: FSM states and
// the one-hot result word {Maior, Menor, Igual}.
package comparador_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam logic [2:0] RES_IGUAL = 3'b001;
    localparam logic [2:0] RES_MENOR = 3'b010;
    localparam logic [2:0] RES_MAIOR = 3'b100;

endpackage

// File: rtl/comparador_digito.sv
// Combinational compare cell for one DIGIT-bit slice; flip_msb inverts the
// slice's top bit on both sides so a two's-complement sign slice orders correctly.
module comparador_digito #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_slice,
    input  logic [DIGIT-1:0] b_slice,
    input  logic             flip_msb,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    logic [DIGIT-1:0] w_mask;
    logic [DIGIT-1:0] w_a;
    logic [DIGIT-1:0] w_b;

    always_comb begin
        w_mask            = '0;
        w_mask[DIGIT-1]   = flip_msb;
        w_a               = a_slice ^ w_mask;
        w_b               = b_slice ^ w_mask;
        eq                = (w_a == w_b);
        lt                = (w_a < w_b);
        gt                = !eq && !lt;
    end

endmodule

// File: rtl/comparador_serial.sv
// Multi-cycle magnitude comparator: walks the latched operands one DIGIT-bit
// slice per clock, MSB-first, and finishes at the first differing slice.
module comparador_serial
    import comparador_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             Igual,
    output logic             Menor,
    output logic             Maior
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NSLICE - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sm;
    logic [IDX_W-1:0] r_idx;
    logic [2:0]       r_res;

    logic [DIGIT-1:0] w_a_slice;
    logic [DIGIT-1:0] w_b_slice;
    logic             w_flip;
    logic             w_eq;
    logic             w_lt;
    logic             w_gt;
    logic             w_last;
    logic             w_finish;

    assign w_a_slice = r_a[r_idx*DIGIT +: DIGIT];
    assign w_b_slice = r_b[r_idx*DIGIT +: DIGIT];
    // Only the most-significant slice carries the sign bit.
    assign w_flip    = r_sm && (r_idx == IDX_TOP);
    assign w_last    = (r_idx == '0);
    assign w_finish  = !w_eq || w_last;

    comparador_digito #(.DIGIT(DIGIT)) u_digito (
        .a_slice  (w_a_slice),
        .b_slice  (w_b_slice),
        .flip_msb (w_flip),
        .eq       (w_eq),
        .lt       (w_lt),
        .gt       (w_gt)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_RUN;
            ST_RUN:  if (w_finish) w_next = ST_FIN;
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == ST_RUN) || (r_state == ST_FIN);
        done = (r_state == ST_FIN);
    end

    // Operands, slice index and result word; results change only on RUN->FIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sm  <= 1'b0;
            r_idx <= '0;
            r_res <= '0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_a   <= A;
                r_b   <= B;
                r_sm  <= signed_mode;
                r_idx <= IDX_TOP;
            end else if (r_state == ST_RUN) begin
                if (!w_eq)       r_res <= w_gt ? RES_MAIOR : RES_MENOR;
                else if (w_last) r_res <= RES_IGUAL;
                else             r_idx <= r_idx - 1'b1;
            end
        end
    end

    assign Igual = |(r_res & RES_IGUAL);
    assign Menor = |(r_res & RES_MENOR);
    assign Maior = |(r_res & RES_MAIOR);

endmodule

// File: tb/tb_comparador_serial.sv
// Bench for comparador_serial: five instances (DIGIT 1,2,4,8,16 at WIDTH 16)
// share stimulus and are checked against a plain-arithmetic reference.
module tb_comparador_serial;

    localparam int W  = 16;
    localparam int NI = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          signed_mode;
    logic [NI-1:0] w_busy, w_done, w_igual, w_menor, w_maior;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int c0  = 0;
    int done_total [NI];
    int busy_total [NI];
    int done_cyc   [NI];
    int done_res   [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        comparador_serial #(.WIDTH(W), .DIGIT(1 << g)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .start       (start),
            .A           (A),
            .B           (B),
            .signed_mode (signed_mode),
            .busy        (w_busy[g]),
            .done        (w_done[g]),
            .Igual       (w_igual[g]),
            .Menor       (w_menor[g]),
            .Maior       (w_maior[g])
        );
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < NI; i++) begin
            done_total[i] = 0;
            busy_total[i] = 0;
            done_cyc[i]   = 0;
            done_res[i]   = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (w_done[i]) begin
                done_total[i] <= done_total[i] + 1;
                done_cyc[i]   <= cyc;
                done_res[i]   <= {29'd0, w_maior[i], w_menor[i], w_igual[i]};
            end
            if (w_busy[i]) busy_total[i] <= busy_total[i] + 1;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Reference result word {Maior, Menor, Igual}
    function automatic int ref_res(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
        logic signed [W-1:0] sa, sb;
        sa = a;
        sb = b;
        if (a == b) return 1;
        if (sm) return (sa < sb) ? 2 : 4;
        return (a < b) ? 2 : 4;
    endfunction

    // Cycles from the accepting edge (inclusive) until done is visible
    function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b, input int dig);
        logic [W-1:0] x;
        int p;
        x = a ^ b;
        if (x == '0) return W / dig + 1;
        p = 0;
        for (int i = 0; i < W; i++) if (x[i]) p = i;
        return (W / dig - p / dig) + 1;
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm, input bit poke);
        int base_d [NI];
        int base_b [NI];
        bit all_done;
        int dig;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            base_d[i] = done_total[i];
            base_b[i] = busy_total[i];
        end
        A = a; B = b; signed_mode = sm; start = 1'b1;
        @(posedge clk);
        #1;
        c0    = cyc;
        start = 1'b0;
        A = $urandom; B = $urandom; signed_mode = $urandom_range(0, 1);
        if (poke) begin
            @(negedge clk);
            A = 16'h0000; B = 16'h0001; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        all_done = 1'b0;
        for (int t = 0; t < 40 && !all_done; t++) begin
            @(negedge clk);
            #1;
            all_done = 1'b1;
            for (int i = 0; i < NI; i++)
                if (done_total[i] == base_d[i]) all_done = 1'b0;
        end
        check("timeout", int'(all_done), 1);
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            dig = 1 << i;
            check($sformatf("ndone d%0d", dig), done_total[i] - base_d[i], 1);
            check($sformatf("lat d%0d", dig), done_cyc[i] - c0 + 1, ref_lat(a, b, dig));
            check($sformatf("busy d%0d", dig), busy_total[i] - base_b[i], ref_lat(a, b, dig));
            check($sformatf("res d%0d", dig), done_res[i], ref_res(a, b, sm));
            check($sformatf("onehot d%0d", dig), $countones(done_res[i]), 1);
        end
    endtask

    initial begin
        int base0;
        logic [W-1:0] ra, rb;
        rst = 1'b1; start = 1'b0; A = '0; B = '0; signed_mode = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst busy", int'(w_busy), 0);
        check("rst done", int'(w_done), 0);
        check("rst res", int'(w_igual | w_menor | w_maior), 0);
        rst = 1'b0;

        run_op(16'h1234, 16'h1234, 1'b0, 1'b0);
        check("eq lat d1", done_cyc[0] - c0 + 1, 17);
        check("eq res d1", done_res[0], 1);

        run_op(16'h8000, 16'h7FFF, 1'b0, 1'b0);
        check("u8000 lat d1", done_cyc[0] - c0 + 1, 2);
        check("u8000 res d1", done_res[0], 4);
        run_op(16'h8000, 16'h7FFF, 1'b1, 1'b0);
        check("s8000 res d1", done_res[0], 2);

        run_op(16'hFFFE, 16'hFFFF, 1'b1, 1'b0);
        check("neg lat d4", done_cyc[2] - c0 + 1, 5);
        check("neg res d4", done_res[2], 2);

        run_op(16'hFFFF, 16'h0000, 1'b0, 1'b0);
        check("ones res d1", done_res[0], 4);

        run_op(16'h1234, 16'h1234, 1'b0, 1'b1);
        check("poke res d1", done_res[0], 1);

        // Abort in the third RUN cycle of a full-length operation
        @(negedge clk);
        base0 = done_total[0];
        A = 16'h5555; B = 16'h5555; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("abort busy", int'(w_busy), 0);
        check("abort done", int'(w_done), 0);
        check("abort res", int'(w_igual | w_menor | w_maior), 0);
        check("abort ndone", done_total[0] - base0, 0);
        rst = 1'b0;
        run_op(16'hA5A5, 16'hA5A4, 1'b0, 1'b0);
        check("post res d1", done_res[0], 4);

        for (int m = 0; m < 2; m++) begin
            for (int n = 0; n < 1000; n++) begin
                ra = $urandom;
                case ($urandom_range(0, 3))
                    0:       rb = ra;
                    1:       rb = ra ^ (16'h0001 << $urandom_range(0, 15));
                    default: rb = $urandom;
                endcase
                run_op(ra, rb, m[0], 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
